// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//   Per-output-port arbiter of the NoC router (one instance per output
//   N/E/W/S/L). Round-robin picks one requesting input while idle, then locks
//   the output to that input for the whole packet (HEADER..TAIL). Flits move
//   only while the granted FIFO is non-empty and the downstream has credit.
//
// Parameters
//   NIN          number of input ports (0=N,1=E,2=W,3=S,4=L)
//   FID_W        flit_id width
//   TIMEOUT_CYC  stall cycles before a forced release (ARB_TIMEOUT_EN only)
//   FID_TAIL     flit_id encoding of a TAIL flit. Only TAIL ends a packet; a
//                HEADER seen while locked is handled like a PAYLOAD flit.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous, active-high reset
//   req      in   [NIN]        route requests for this output
//   valid    in   [NIN]        input FIFO non-empty
//   flit_id  in   [NIN*FID_W]  head-flit id, input i at [i*FID_W +: FID_W]
//   credit   in   downstream can accept a flit this cycle
//   grant    out  [NIN]        one-hot grant (registered)
//   sel      out  [3]          crossbar select, 0 when idle (registered)
//   xfer     out  flit transferred this cycle (combinational)
//   rd_en    out  [NIN]        FIFO pop (combinational)
//   timeout  out  one-cycle forced-release pulse (only with ARB_TIMEOUT_EN)
//   busy     out  a packet owns the output (registered)
//
// Configuration macro
//   ARB_TIMEOUT_EN  adds the stall watchdog and the timeout output.
// ---------------------------------------------------------------------------
module output_port_arbiter #(
  parameter int               NIN         = 5,
  parameter int               FID_W       = 3,
  parameter int               TIMEOUT_CYC = 64,
  parameter logic [FID_W-1:0] FID_TAIL    = FID_W'(4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIN-1:0]       req,
  input  logic [NIN-1:0]       valid,
  input  logic [NIN*FID_W-1:0] flit_id,
  input  logic                 credit,
  output logic [NIN-1:0]       grant,
  output logic [2:0]           sel,
  output logic                 xfer,
  output logic [NIN-1:0]       rd_en,
`ifdef ARB_TIMEOUT_EN
  output logic                 timeout,
`endif
  output logic                 busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q;
  logic [NIN-1:0]   grant_q;
  logic [2:0]       sel_q;
  logic [2:0]       rr_ptr_q;
  logic             busy_q;

  logic             pick_vld;
  logic [2:0]       pick_idx;
  logic [FID_W-1:0] cur_fid;
  logic             is_tail;

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;
`endif

  // (v + 1) mod NIN on the 3-bit pointer
  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    if (int'(v) >= NIN - 1) return 3'd0;
    return v + 3'd1;
  endfunction

  // Round-robin search: scan offsets from the far end down so the set bit
  // closest to rr_ptr (offset 0 first) is the last, and therefore final, hit.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    for (int off = NIN - 1; off >= 0; off--) begin
      if (req[(int'(rr_ptr_q) + off) % NIN]) begin
        pick_vld = 1'b1;
        pick_idx = 3'((int'(rr_ptr_q) + off) % NIN);
      end
    end
  end

  // flit_id of the granted input; grant is one-hot so at most one term hits
  always_comb begin
    cur_fid = '0;
    for (int i = 0; i < NIN; i++) begin
      if (grant_q[i]) cur_fid = flit_id[i*FID_W +: FID_W];
    end
  end

  assign is_tail = (cur_fid == FID_TAIL);

  // rst gates the transfer so a reset mid-packet never pops a flit
  assign xfer  = ~rst & (state_q == LOCK) & (|(grant_q & valid)) & credit;
  assign rd_en = grant_q & {NIN{xfer}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= 3'd0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= NIN'(1) << pick_idx;
            sel_q   <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= LOCK;
`ifdef ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
          end
        end
        LOCK: begin
          // req is deliberately ignored here: only TAIL (or the watchdog)
          // releases the output.
          if (xfer && is_tail) begin
            grant_q  <= '0;
            sel_q    <= 3'd0;
            busy_q   <= 1'b0;
            rr_ptr_q <= wrap_inc(sel_q);
            state_q  <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (xfer) begin
            stall_q <= '0;
          end else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            // this stalled cycle brings the count to TIMEOUT_CYC
            grant_q   <= '0;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
            rr_ptr_q  <= wrap_inc(sel_q);
            state_q   <= IDLE;
            stall_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule
